reg_file_wb: RTL and testbench

Register file with write-back scoreboard for the pRISC datapath. Receives the 5-bit destination address chosen by the write-register select mux, together with write-back data, and commits it. Serves two combinational read ports to decode. Tracks in-flight destinations so decode can detect read-after-write hazards and stall.

---
 rtl/reg_file_wb.sv | 138 +++++++++++++
 tb/tb_reg_file_wb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb
// Purpose  : pRISC register file with write-back scoreboard. NREG x DATA_W
//            storage, two combinational read ports for decode, and one
//            pending bit per register so decode can detect RAW hazards.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            rs_addr / rt_addr    - read port addresses
//            rs_data / rt_data    - read port data (combinational)
//            rs_busy / rt_busy    - read address has a pending producer
//            claim_en, claim_addr - decode claims a destination register
//            wr_en, wr_addr,
//            wr_data              - write-back commit
//            pending              - registered scoreboard vector
// Options  : REGFILE_BYPASS_EN - when defined, a read matching the current
//            write-back sees wr_data and busy=0 in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              claim_en,
  input  logic [4:0]        claim_addr,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [NREG-1:0]   pending
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;

  // Address range qualifiers: the address bus is fixed at 5 bits even when
  // NREG is smaller, so out-of-range accesses read as zero and are ignored.
  logic w_wr_ok;
  logic w_claim_ok;
  logic w_rs_ok;
  logic w_rt_ok;

  assign w_wr_ok    = (int'(wr_addr)    < NREG);
  assign w_claim_ok = (int'(claim_addr) < NREG);
  assign w_rs_ok    = (int'(rs_addr)    < NREG);
  assign w_rt_ok    = (int'(rt_addr)    < NREG);

  // Next-state for storage and scoreboard.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    pending_d = pending_q;

    if (wr_en && w_wr_ok) begin
      regs_d[wr_addr]    = wr_data;
      pending_d[wr_addr] = 1'b0;
    end
    // Applied after the clear so that a same-address claim wins: the claim
    // represents a newer producer than the one now retiring.
    if (claim_en && w_claim_ok) begin
      pending_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
    end
  end

  // Read path.
  logic [DATA_W-1:0] w_rs_stored;
  logic [DATA_W-1:0] w_rt_stored;
  logic              w_rs_pend;
  logic              w_rt_pend;

  always_comb begin
    w_rs_stored = '0;
    w_rt_stored = '0;
    w_rs_pend   = 1'b0;
    w_rt_pend   = 1'b0;
    if (w_rs_ok) begin
      w_rs_stored = regs_q[rs_addr];
      w_rs_pend   = pending_q[rs_addr];
    end
    if (w_rt_ok) begin
      w_rt_stored = regs_q[rt_addr];
      w_rt_pend   = pending_q[rt_addr];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the retiring value. Gated by rst_n so that outputs stay zero
  // while reset is asserted even if a write is being presented.
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = rst_n && wr_en && w_wr_ok && (wr_addr == rs_addr);
  assign w_rt_hit = rst_n && wr_en && w_wr_ok && (wr_addr == rt_addr);

  always_comb begin
    rs_data = w_rs_hit ? wr_data : w_rs_stored;
    rt_data = w_rt_hit ? wr_data : w_rt_stored;
    // Busy follows only the write match, even if a claim re-sets the bit
    // on this same edge; that new producer is seen the following cycle.
    rs_busy = w_rs_hit ? 1'b0 : w_rs_pend;
    rt_busy = w_rt_hit ? 1'b0 : w_rt_pend;
  end
`else
  always_comb begin
    rs_data = w_rs_stored;
    rt_data = w_rt_stored;
    rs_busy = w_rs_pend;
    rt_busy = w_rt_pend;
  end
`endif

  assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb
// Purpose  : Self-checking bench for reg_file_wb. Table of per-cycle vectors
//            (inputs plus expected outputs seen before the committing edge),
//            plus hand-written reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [4:0]        rs_addr;
  logic [4:0]        rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              claim_en;
  logic [4:0]        claim_addr;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   pending;

  reg_file_wb #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ce;
    logic [4:0]  ca;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] e_rs;   // expected without bypass
    logic [31:0] e_rt;
    logic        e_rsb;
    logic        e_rtb;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[17];

  task automatic idle_inputs();
    claim_en   = 1'b0;
    claim_addr = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
  endtask

  initial begin
    //            ce  ca     we  wa     wd             ra     rb     e_rs           e_rt           rsb  rtb  pend
    vecs[0]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd3,  5'd0,  32'h0,         32'h0,         1'b0,1'b0,32'h0};
    vecs[1]  = '{1'b0, 5'd0,  1'b1, 5'd31, 32'h0000_1234, 5'd31, 5'd31, 32'h0,         32'h0,         1'b0,1'b0,32'h0};
    vecs[2]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd31, 5'd0,  32'h0000_1234, 32'h0,         1'b0,1'b0,32'h0};
    vecs[3]  = '{1'b1, 5'd5,  1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h0,         32'h0,         1'b0,1'b0,32'h0};
    vecs[4]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'h0,         1'b0,1'b1,32'h0000_0020};
    vecs[5]  = '{1'b0, 5'd0,  1'b1, 5'd5,  32'h55,        5'd0,  5'd5,  32'h0,         32'h0,         1'b0,1'b1,32'h0000_0020};
    vecs[6]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h55,        32'h55,        1'b0,1'b0,32'h0};
    vecs[7]  = '{1'b1, 5'd7,  1'b0, 5'd0,  32'h0,         5'd7,  5'd0,  32'h0,         32'h0,         1'b0,1'b0,32'h0};
    vecs[8]  = '{1'b1, 5'd7,  1'b1, 5'd7,  32'h77,        5'd7,  5'd0,  32'h0,         32'h0,         1'b1,1'b0,32'h0000_0080};
    vecs[9]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'h77,        32'h77,        1'b1,1'b1,32'h0000_0080};
    vecs[10] = '{1'b0, 5'd0,  1'b1, 5'd1,  32'hA,         5'd0,  5'd0,  32'h0,         32'h0,         1'b0,1'b0,32'h0000_0080};
    vecs[11] = '{1'b0, 5'd0,  1'b1, 5'd2,  32'hB,         5'd1,  5'd2,  32'hA,         32'h0,         1'b0,1'b0,32'h0000_0080};
    vecs[12] = '{1'b0, 5'd0,  1'b1, 5'd7,  32'h7007,      5'd1,  5'd2,  32'hA,         32'hB,         1'b0,1'b0,32'h0000_0080};
    vecs[13] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd2,  5'd2,  32'hB,         32'hB,         1'b0,1'b0,32'h0};
    vecs[14] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd7,  5'd31, 32'h7007,      32'h0000_1234, 1'b0,1'b0,32'h0};
    vecs[15] = '{1'b1, 5'd31, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, 32'h0000_1234, 32'h0000_1234, 1'b0,1'b0,32'h0};
    vecs[16] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,1'b1,32'h8000_0000};

    // ---------------- Reset with a write and claim presented -------------
    rst_n      = 1'b0;
    rs_addr    = 5'd3;
    rt_addr    = 5'd3;
    claim_en   = 1'b1;
    claim_addr = 5'd3;
    wr_en      = 1'b1;
    wr_addr    = 5'd3;
    wr_data    = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_rs_data", rs_data, 32'h0);
    check("rst_hold_rt_busy", {31'b0, rt_busy}, 32'h0);
    check("rst_hold_pending", pending, 32'h0);
    idle_inputs();
    rst_n = 1'b1;

    // ---------------- Table-driven vectors ----------------
    for (int i = 0; i < 17; i++) begin
      logic [31:0] ers, ert;
      logic        ersb, ertb;
      @(negedge clk);
      claim_en   = vecs[i].ce;
      claim_addr = vecs[i].ca;
      wr_en      = vecs[i].we;
      wr_addr    = vecs[i].wa;
      wr_data    = vecs[i].wd;
      rs_addr    = vecs[i].ra;
      rt_addr    = vecs[i].rb;
      ers  = vecs[i].e_rs;
      ert  = vecs[i].e_rt;
      ersb = vecs[i].e_rsb;
      ertb = vecs[i].e_rtb;
      // Bypass build: a read matching the live write sees wr_data, not busy.
      if (BYP && vecs[i].we && vecs[i].wa == vecs[i].ra) begin
        ers  = vecs[i].wd;
        ersb = 1'b0;
      end
      if (BYP && vecs[i].we && vecs[i].wa == vecs[i].rb) begin
        ert  = vecs[i].wd;
        ertb = 1'b0;
      end
      #2;
      check($sformatf("v%0d_rs_data", i), rs_data, ers);
      check($sformatf("v%0d_rt_data", i), rt_data, ert);
      check($sformatf("v%0d_rs_busy", i), {31'b0, rs_busy}, {31'b0, ersb});
      check($sformatf("v%0d_rt_busy", i), {31'b0, rt_busy}, {31'b0, ertb});
      check($sformatf("v%0d_pending", i), pending, vecs[i].e_pend);
    end

    // ---------------- Fill every register and claim all ----------------
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      claim_en   = 1'b1;
      claim_addr = 5'(i);
      wr_en      = 1'b1;
      wr_addr    = 5'(i);
      wr_data    = 32'(i + 1);
    end
    @(negedge clk);
    idle_inputs();
    rs_addr = 5'd4;
    rt_addr = 5'd9;
    #2;
    check("full_pending", pending, 32'hFFFF_FFFF);
    check("full_rs_data", rs_data, 32'd5);
    check("full_rt_data", rt_data, 32'd10);
    check("full_rs_busy", {31'b0, rs_busy}, 32'h1);

    // ---------------- Asynchronous mid-cycle reset pulse ----------------
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_addr = 5'd4;
    wr_data = 32'h1111_2222;
    rst_n   = 1'b0;
    #1;
    check("arst_rs_data", rs_data, 32'h0);
    check("arst_rt_data", rt_data, 32'h0);
    check("arst_rs_busy", {31'b0, rs_busy}, 32'h0);
    check("arst_rt_busy", {31'b0, rt_busy}, 32'h0);
    check("arst_pending", pending, 32'h0);
    @(negedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("post_rst_rs_data", rs_data, 32'h0);
    check("post_rst_pending", pending, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
